// File: rtl/spr_serial_rx.sv
// Sprite-command serial link receiver: synchronises spr_clk/spr_cmd/spr_ser,
// frames the stream into command and data fields, and flags short/long/stalled frames.
module spr_serial_rx #(
  parameter int CMD_BITS     = 4,
  parameter int DATA_BITS    = 16,
  parameter int SYNC_STAGES  = 2,
  parameter int TIMEOUT      = 4096,
  parameter int ERR_CNT_BITS = 8,
  localparam int DW          = (DATA_BITS > 0) ? DATA_BITS : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    spr_clk,
  input  logic                    spr_cmd,
  input  logic                    spr_ser,
  output logic [CMD_BITS-1:0]     cmd_out,
  output logic [DW-1:0]           data_out,
  output logic                    frame_valid,
  output logic                    frame_err,
  output logic                    busy,
  output logic [ERR_CNT_BITS-1:0] err_count
);

  localparam int FRAME = CMD_BITS + DATA_BITS;
  localparam int BCW   = $clog2(FRAME + 2);
  localparam int TOW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [BCW-1:0] FRAME_C = BCW'(FRAME);
  localparam logic [BCW-1:0] BC_MAX  = BCW'(FRAME + 1);
  localparam logic [TOW-1:0] TO_LAST = TOW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SHIFT     = 2'd1,
    WAIT_IDLE = 2'd2
  } state_t;

  // All three pins share the same depth so spr_ser stays aligned with its spr_clk edge.
  logic [SYNC_STAGES-1:0] clk_sync, cmd_sync, ser_sync;
  logic                   clk_d, cmd_d;

  always_ff @(posedge clk) begin
    clk_sync <= {clk_sync[SYNC_STAGES-2:0], spr_clk};
    cmd_sync <= {cmd_sync[SYNC_STAGES-2:0], spr_cmd};
    ser_sync <= {ser_sync[SYNC_STAGES-2:0], spr_ser};
    clk_d    <= clk_sync[SYNC_STAGES-1];
    cmd_d    <= cmd_sync[SYNC_STAGES-1];
  end

  logic clk_s, cmd_s, ser_s, clk_rise, cmd_rise, cmd_fall;
  assign clk_s    = clk_sync[SYNC_STAGES-1];
  assign cmd_s    = cmd_sync[SYNC_STAGES-1];
  assign ser_s    = ser_sync[SYNC_STAGES-1];
  assign clk_rise = clk_s & ~clk_d;
  assign cmd_rise = cmd_s & ~cmd_d;
  assign cmd_fall = ~cmd_s & cmd_d;

  state_t           state_q, state_d;
  logic [FRAME-1:0] shift_q, shift_d;
  logic [BCW-1:0]   bcnt_q, bcnt_d;
  logic [TOW-1:0]   to_q, to_d;
  logic             load, err;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bcnt_d  = bcnt_q;
    to_d    = to_q;
    load    = 1'b0;
    err     = 1'b0;
    case (state_q)
      WAIT_IDLE: if (!cmd_s) state_d = IDLE;
      IDLE: begin
        if (cmd_rise) begin
          state_d = SHIFT;
          bcnt_d  = '0;
          to_d    = '0;
        end
      end
      SHIFT: begin
        // A frame end wins over a coincident bit edge: that bit is dropped.
        if (cmd_fall) begin
          state_d = IDLE;
          if (bcnt_q == FRAME_C) load = 1'b1;
          else                   err  = 1'b1;
        end else if (clk_rise && cmd_s) begin
          shift_d    = shift_q << 1;
          shift_d[0] = ser_s;
          if (bcnt_q != BC_MAX) bcnt_d = bcnt_q + BCW'(1);
          to_d = '0;
        end else if (TIMEOUT != 0 && to_q == TO_LAST) begin
          err     = 1'b1;
          state_d = WAIT_IDLE;
        end else begin
          to_d = to_q + TOW'(1);
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  logic [DW-1:0] data_nxt;
  generate
    if (DATA_BITS > 0) begin : g_data
      assign data_nxt = shift_q[DW-1:0];
    end else begin : g_nodata
      assign data_nxt = '0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= WAIT_IDLE;
      shift_q     <= '0;
      bcnt_q      <= '0;
      to_q        <= '0;
      cmd_out     <= '0;
      data_out    <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
      err_count   <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bcnt_q      <= bcnt_d;
      to_q        <= to_d;
      frame_valid <= load;
      frame_err   <= err;
      busy        <= (state_d == SHIFT);
      if (load) begin
        cmd_out  <= shift_q[FRAME-1:DATA_BITS];
        data_out <= data_nxt;
      end
      if (err && err_count != '1) err_count <= err_count + ERR_CNT_BITS'(1);
    end
  end

endmodule
